// File: rtl/sudoku_game_ctrl.sv
// Sudoku game-flow controller: merges debounced buttons and Bluetooth bytes into one
// command stream, owns the 9x9 cursor and sequences board writes and solution checks.
module sudoku_game_ctrl #(
  parameter int DEB_CYCLES = 2
) (
  input  logic       CLK_100MHz,
  input  logic       RST_n,
  input  logic       BTN_U,
  input  logic       BTN_D,
  input  logic       BTN_L,
  input  logic       BTN_R,
  input  logic       BTN_C,
  input  logic       bt_valid,
  input  logic [7:0] bt_data,
  output logic       bt_ready,
  input  logic       fixed_cell,
  output logic [3:0] cur_row,
  output logic [3:0] cur_col,
  output logic       wr_req,
  output logic [6:0] wr_addr,
  output logic [3:0] wr_data,
  input  logic       wr_ack,
  output logic       chk_start,
  input  logic       chk_done,
  input  logic       chk_ok,
  output logic [1:0] game_state,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_WRITE, S_POST, S_START, S_WAIT, S_WIN
  } state_t;

  typedef enum logic [2:0] {K_U, K_D, K_L, K_R, K_C, K_DIG} kind_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] DEB_MAX  = 8'(DEB_CYCLES);

  state_t      state, state_nx;
  logic [4:0]  raw, sync1, sync2, btn_evt;
  logic [7:0]  deb_cnt [5];
  logic        btn_any, busy, alive;
  logic        cmd_vld, cmd_in_vld;
  kind_t       cmd_kind, cmd_in_kind;
  logic [3:0]  cmd_val, cmd_in_val;
  logic [3:0]  row_q, col_q, row_nx, col_nx;
  logic [6:0]  addr_q, addr_nx, cell_addr;
  logic [3:0]  data_q, data_nx;

  // Bit order is the arbitration order: C, U, D, L, R from MSB down.
  assign raw = {BTN_C, BTN_U, BTN_D, BTN_L, BTN_R};

  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      sync1 <= '0;
      sync2 <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        if (!sync2[i])                 deb_cnt[i] <= '0;
        else if (deb_cnt[i] != DEB_MAX) deb_cnt[i] <= deb_cnt[i] + 8'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) btn_evt[i] = sync2[i] && (deb_cnt[i] == DEB_LAST);
  end

  assign btn_any = |btn_evt;
  assign busy    = (state == S_WRITE) || (state == S_POST) ||
                   (state == S_START) || (state == S_WAIT);

  // Handshake: a byte is consumed on an edge where bt_valid && bt_ready. A button event
  // in the same cycle takes the command slot, so the byte is held to a later cycle.
  assign bt_ready = alive && !busy && !btn_any;

  always_comb begin
    cmd_in_vld  = 1'b0;
    cmd_in_kind = K_U;
    cmd_in_val  = 4'd0;
    if (btn_any && !busy) begin
      cmd_in_vld = 1'b1;
      if      (btn_evt[4]) cmd_in_kind = K_C;
      else if (btn_evt[3]) cmd_in_kind = K_U;
      else if (btn_evt[2]) cmd_in_kind = K_D;
      else if (btn_evt[1]) cmd_in_kind = K_L;
      else                 cmd_in_kind = K_R;
    end else if (bt_valid && bt_ready) begin
      cmd_in_vld = 1'b1;
      if (bt_data >= 8'h30 && bt_data <= 8'h39) begin
        cmd_in_kind = K_DIG;
        cmd_in_val  = bt_data[3:0];
      end else begin
        case (bt_data)
          8'h55:   cmd_in_kind = K_U;
          8'h44:   cmd_in_kind = K_D;
          8'h4C:   cmd_in_kind = K_L;
          8'h52:   cmd_in_kind = K_R;
          8'h43:   cmd_in_kind = K_C;
          default: cmd_in_vld  = 1'b0;
        endcase
      end
    end
  end

  assign cell_addr = {3'b000, row_q} * 7'd9 + {3'b000, col_q};

  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      state    <= S_IDLE;
      alive    <= 1'b0;
      cmd_vld  <= 1'b0;
      cmd_kind <= K_U;
      cmd_val  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nx;
      alive    <= 1'b1;
      cmd_vld  <= cmd_in_vld;
      cmd_kind <= cmd_in_kind;
      cmd_val  <= cmd_in_val;
      row_q    <= row_nx;
      col_q    <= col_nx;
      addr_q   <= addr_nx;
      data_q   <= data_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row_q;
    col_nx   = col_q;
    addr_nx  = addr_q;
    data_nx  = data_q;
    case (state)
      S_IDLE: if (cmd_vld && cmd_kind == K_C) begin
        state_nx = S_PLAY;
        row_nx   = 4'd0;
        col_nx   = 4'd0;
      end
      S_PLAY: if (cmd_vld) begin
        case (cmd_kind)
          K_U: row_nx = (row_q == 4'd0) ? 4'd8 : row_q - 4'd1;
          K_D: row_nx = (row_q == 4'd8) ? 4'd0 : row_q + 4'd1;
          K_L: col_nx = (col_q == 4'd0) ? 4'd8 : col_q - 4'd1;
          K_R: col_nx = (col_q == 4'd8) ? 4'd0 : col_q + 4'd1;
          default: if (!fixed_cell) begin
            state_nx = S_WRITE;
            addr_nx  = cell_addr;
            data_nx  = (cmd_kind == K_C) ? 4'd0 : cmd_val;
          end
        endcase
      end
      S_WRITE: if (wr_ack) state_nx = S_POST;
      S_POST:  state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT:  if (chk_done) state_nx = chk_ok ? S_WIN : S_PLAY;
      S_WIN:   if (cmd_vld && cmd_kind == K_C) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign wr_req     = (state == S_WRITE);
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign chk_start  = (state == S_START);
  assign game_state = (state == S_IDLE) ? 2'd0 :
                      (state == S_PLAY) ? 2'd1 :
                      (state == S_WIN)  ? 2'd3 : 2'd2;
  assign dbg_state  = state;

endmodule

// File: doc/sudoku_game_ctrl.md
# sudoku_game_ctrl

Game-flow controller for the Sudoku design: merges the five board buttons (U/D/L/R/C) and Bluetooth command bytes into one command stream. It owns the 9×9 cursor and sequences the game FSM. It drives board-RAM write requests and solution checks through req/ack handshakes. It sits between the raw inputs of the top module and the board memory, checker and VGA renderer; the renderer uses its cursor and state outputs.

## Interface
- DEB_CYCLES, 2: consecutive synchronized-high cycles before a button press registers. Range 1..255.
- CLK_100MHz  in  1  system clock, rising edge
- RST_n  in  1  asynchronous, active-low reset
- BTN_U, BTN_D, BTN_L, BTN_R, BTN_C  in  1 each  raw asynchronous buttons, active high
- bt_valid  in  1  Bluetooth byte valid
- bt_data  in  8  ASCII command: '0'..'9', 'U','D','L','R','C'
- bt_ready  out  1  byte is consumed on any edge with bt_valid && bt_ready
- fixed_cell  in  1  the cell at {cur_row,cur_col} is a given clue. Valid combinationally.
- cur_row, cur_col  out  4 each  cursor position, 0..8
- wr_req  out  1  board write request, held until ack
- wr_addr  out  7  cur_row*9+cur_col, frozen while wr_req is high
- wr_data  out  4  value 0..9, where 0 means clear
- wr_ack  in  1  one-cycle write acknowledge
- chk_start  out  1  one-cycle pulse that starts the board check
- chk_done  in  1  one-cycle check completion
- chk_ok  in  1  board solved. Valid only with chk_done.
- game_state  out  2  0 IDLE, 1 PLAY, 2 BUSY, 3 WIN

## Operation
- Each button passes through a 2-FF synchronizer and then a debounce counter. A press event is a one-cycle pulse raised once the synchronized level has been high for DEB_CYCLES edges. Releasing resets the counter. Holding the button produces no repeat events.
- If several button events fire on the same edge, priority is C > U > D > L > R. The losers are dropped.
- Arbitration between sources: a button event wins. bt_ready is low on any cycle where a button event is pending, so the Bluetooth byte stays held for the next cycle.
- bt_ready = (state != BUSY) && !button_event.
- A Bluetooth 'U','D','L','R','C' byte acts exactly like the matching button. Digits '1'..'9' write that value, and '0' clears the cell. Any other byte is consumed and ignored.
- IDLE: C → PLAY, and the cursor is set to (0,0). All other commands are ignored.
- PLAY, movement: U/D change the row by −1/+1 and L/R change the column by −1/+1, with wrap-around (row 0 + U → 8; col 8 + R → 0).
- PLAY, writes: a digit writes that value and C writes 0.
  - If fixed_cell is 1, the write is ignored and the state stays PLAY.
  - Otherwise the block enters BUSY: it latches wr_addr/wr_data and asserts wr_req.
- BUSY, write phase: wr_req stays high until the edge on which wr_ack is sampled; it drops on the following edge. On the next edge chk_start pulses for one cycle.
- BUSY, check phase: the block then waits for chk_done.
  - chk_done && chk_ok → WIN.
  - chk_done && !chk_ok → PLAY.
- BUSY, input handling: button events are discarded, and Bluetooth bytes are held back (bt_ready is low). The cursor is frozen.
- WIN: C → IDLE. All other commands are ignored.
- wr_ack or chk_done arriving outside its wait phase is ignored.

## Timing
- Reset values: game_state 0, cur_row 0, cur_col 0, wr_req 0, wr_addr 0, wr_data 0, chk_start 0, bt_ready 0. Synchronizers and debounce counters clear to 0.
- Reset mid-operation: the block returns to IDLE immediately (asynchronously) and abandons any pending write or check. bt_ready rises on the first edge after RST_n deasserts.
- Button latency: the action (cursor or state register update) occurs DEB_CYCLES+3 rising edges after the first edge that samples the raw button high. That is 2 synchronizer stages + DEB_CYCLES stable edges + 1 action edge.
- Bluetooth latency: the action is registered on the edge after the handshake edge.
- Write path:
  - wr_req rises 1 edge after the digit command is accepted.
  - chk_start pulses 1 edge after wr_req falls.
  - game_state updates on the edge after chk_done is sampled.
- Throughput: at most one command per cycle in PLAY. No commands are accepted in BUSY.

## Test plan
- Reset, DEB_CYCLES=2: hold RST_n=0 and check all outputs are 0. Pulse BTN_C for 4 cycles → game_state=1 exactly 5 edges after first sampling, cursor (0,0).
- Wrap: in PLAY at (0,0), press BTN_L three times, then BTN_U twice → cur_col=6 after the L presses, cur_row=7 after the U presses. One press per event; no repeats while a button is held.
- Arbitration: BTN_R event on the same edge as bt_valid with 'D' → bt_ready is low on that cycle. Column changes first, then row on the next cycle; final (1,1) from (0,0).
- Write handshake: Bluetooth '7' at (2,3) with fixed_cell=0 → wr_req=1, wr_addr=21, wr_data=7, held for 5 cycles until wr_ack. Then one chk_start pulse; chk_done with chk_ok=0 → game_state=1.
- Fixed cell and busy: '5' with fixed_cell=1 → no wr_req, state stays PLAY. During BUSY, button presses leave the cursor unchanged and bt_ready=0.
- Win and reset: chk_done with chk_ok=1 → state 3. BTN_C → state 0. Asserting RST_n=0 while wr_req=1 → wr_req=0 immediately, state 0.
